// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Contents: FSM state encoding, line/word geometry, address field positions
// and a word-select helper used by the top.
package icache_direct_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,  // compare incoming fetch against the array
        StAlloc = 1'b1   // line fill outstanding on the memory side
    } state_e;

    localparam int unsigned LINE_W         = 128;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned WORD_W         = 32;

    // Core addresses are word addresses [31:2]; memory addresses are line addresses [31:4].
    localparam int unsigned PROC_ADDR_W = 30;
    localparam int unsigned MEM_ADDR_W  = 28;
    // Word-within-line offset occupies the low bits of the word address.
    localparam int unsigned OFFSET_W    = 2;

    // Pick word 'off' out of a line; word w lives at bits [32w+31:32w].
    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFFSET_W-1:0] off);
        return line[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_direct_if.sv
// Bus bundle for icache_direct: core fetch port plus memory line-fill port.
// slave  : the cache's view (takes core requests, drives memory requests).
// master : the environment's view (core + memory model).
interface icache_direct_if;
    import icache_direct_pkg::*;

    // Core side
    logic                   proc_read;
    logic [PROC_ADDR_W-1:0] proc_addr;
    logic [WORD_W-1:0]      proc_rdata;
    logic                   proc_stall;
    // Memory side
    logic                   mem_read;
    logic [MEM_ADDR_W-1:0]  mem_addr;
    logic [LINE_W-1:0]      mem_rdata;
    logic                   mem_ready;

    modport slave (
        input  proc_read, proc_addr, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_addr
    );

    modport master (
        output proc_read, proc_addr, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_addr
    );

endinterface

// File: rtl/icache_direct_line_array.sv
// icache_line_array: per-line valid/tag/data storage for the direct-mapped cache.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears every register)
//   we, widx, wtag,     single write port: sets valid and loads tag/data at widx
//   wdata
//   ridx                combinational read index
//   rvalid, rtag, rdata read data for ridx
module icache_line_array #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = 25,
    parameter int unsigned LINE_W  = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [INDEX_W-1:0] widx,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [LINE_W-1:0]  wdata,
    input  logic [INDEX_W-1:0] ridx,
    output logic               rvalid,
    output logic [TAG_W-1:0]   rtag,
    output logic [LINE_W-1:0]  rdata
);

    localparam int unsigned LINES = 1 << INDEX_W;

    logic [LINES-1:0]             valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [LINES-1:0][LINE_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[widx] = 1'b1;
            tag_d[widx]   = wtag;
            data_d[widx]  = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache between the core fetch
// port and slow instruction memory. 1-cycle fetch on hit; a miss fetches a whole
// 4-word line over a req/ready handshake.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   bus (slave)         core fetch port + memory line-fill port
//   hit_cnt, miss_cnt   saturating performance counters
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    icache_direct_if.slave   bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int unsigned TAG_W = PROC_ADDR_W - OFFSET_W - INDEX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e                state_q, state_d;
    logic                  mem_read_q, mem_read_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

    logic [OFFSET_W-1:0] req_off;
    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                line_valid;
    logic [TAG_W-1:0]    line_tag;
    logic [LINE_W-1:0]   line_data;
    logic                fill_we;
    logic                hit;

    assign req_off = bus.proc_addr[OFFSET_W-1:0];
    assign req_idx = bus.proc_addr[OFFSET_W +: INDEX_W];
    assign req_tag = bus.proc_addr[PROC_ADDR_W-1 -: TAG_W];

    // The fill writes from the latched line address, never from the live core address.
    icache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .LINE_W  (LINE_W)
    ) u_lines (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (fill_we),
        .widx   (mem_addr_q[INDEX_W-1:0]),
        .wtag   (mem_addr_q[MEM_ADDR_W-1 -: TAG_W]),
        .wdata  (bus.mem_rdata),
        .ridx   (req_idx),
        .rvalid (line_valid),
        .rtag   (line_tag),
        .rdata  (line_data)
    );

    // Hit is only meaningful while comparing; during a fill the core is always stalled.
    assign hit = (state_q == StIdle) && line_valid && (line_tag == req_tag);

    always_comb begin
        state_d    = state_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        fill_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.proc_read) begin
                    if (hit) begin
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_ONE;
                    end else begin
                        state_d    = StAlloc;
                        mem_read_d = 1'b1;
                        mem_addr_d = bus.proc_addr[PROC_ADDR_W-1:OFFSET_W];
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_ONE;
                    end
                end
            end
            StAlloc: begin
                if (bus.mem_ready) begin
                    fill_we    = 1'b1;
                    mem_read_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        bus.proc_stall = (state_q == StAlloc) ? 1'b1 : (bus.proc_read & ~hit);
        bus.proc_rdata = hit ? get_word(line_data, req_off) : '0;
    end

    assign bus.mem_read = mem_read_q;
    assign bus.mem_addr = mem_addr_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct: one instance with default
// parameters, a second with 4-bit counters for saturation.
module tb_icache_direct;

    logic clk;
    logic rst_n;

    icache_direct_if bus_a ();
    icache_direct_if bus_b ();

    logic [31:0] hit_a, miss_a;
    logic [3:0]  hit_b, miss_b;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] LINE0 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINEB = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [127:0] JUNK  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    icache_direct #(.INDEX_W(3), .CNT_W(32)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_a),
        .hit_cnt  (hit_a),
        .miss_cnt (miss_a)
    );

    icache_direct #(.INDEX_W(3), .CNT_W(4)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_b),
        .hit_cnt  (hit_b),
        .miss_cnt (miss_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.proc_read = 1'b0; bus_a.proc_addr = '0; bus_a.mem_rdata = '0; bus_a.mem_ready = 1'b0;
        bus_b.proc_read = 1'b0; bus_b.proc_addr = '0; bus_b.mem_rdata = '0; bus_b.mem_ready = 1'b0;
        #2;
        // Reset state
        check_eq("rst_mem_read", bus_a.mem_read, 0);
        check_eq("rst_mem_addr", bus_a.mem_addr, 0);
        check_eq("rst_hit_cnt", hit_a, 0);
        check_eq("rst_miss_cnt", miss_a, 0);
        check_eq("rst_stall_noread", bus_a.proc_stall, 0);
        bus_a.proc_read = 1'b1;
        #1;
        check_eq("rst_stall_read", bus_a.proc_stall, 1);
        check_eq("rst_rdata", bus_a.proc_rdata, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Cold miss on address 0
        #1;
        check_eq("cold_stall", bus_a.proc_stall, 1);
        tick();
        check_eq("cold_mem_read", bus_a.mem_read, 1);
        check_eq("cold_mem_addr", bus_a.mem_addr, 0);
        check_eq("cold_miss_cnt", miss_a, 1);
        check_eq("cold_alloc_stall", bus_a.proc_stall, 1);
        tick(); tick();
        bus_a.mem_ready = 1'b1; bus_a.mem_rdata = LINE0; bus_a.proc_read = 1'b0;
        tick();
        bus_a.mem_ready = 1'b0; bus_a.mem_rdata = JUNK;
        #1;
        check_eq("fill_rdata", bus_a.proc_rdata, 32'h11111111);
        check_eq("fill_mem_read", bus_a.mem_read, 0);

        // Hits on words 1..3
        bus_a.proc_read = 1'b1; bus_a.proc_addr = 30'd1;
        #1;
        check_eq("hit1_stall", bus_a.proc_stall, 0);
        check_eq("hit1_rdata", bus_a.proc_rdata, 32'h22222222);
        tick();
        bus_a.proc_addr = 30'd2;
        #1;
        check_eq("hit2_rdata", bus_a.proc_rdata, 32'h33333333);
        tick();
        bus_a.proc_addr = 30'd3;
        #1;
        check_eq("hit3_rdata", bus_a.proc_rdata, 32'h44444444);
        tick();
        bus_a.proc_read = 1'b0;
        #1;
        check_eq("hits_hit_cnt", hit_a, 3);
        check_eq("hits_miss_cnt", miss_a, 1);

        // Spurious mem_ready while idle
        bus_a.mem_ready = 1'b1;
        tick();
        bus_a.mem_ready = 1'b0;
        bus_a.proc_addr = 30'd0;
        #1;
        check_eq("spur_mem_read", bus_a.mem_read, 0);
        check_eq("spur_miss_cnt", miss_a, 1);
        check_eq("spur_line_kept", bus_a.proc_rdata, 32'h11111111);

        // Conflict miss: same index 0, tag 1
        bus_a.proc_read = 1'b1; bus_a.proc_addr = 30'h20;
        #1;
        check_eq("conf_stall", bus_a.proc_stall, 1);
        tick();
        check_eq("conf_mem_read", bus_a.mem_read, 1);
        check_eq("conf_mem_addr", bus_a.mem_addr, 28'h8);
        // Core address wanders during the fill; it must be ignored
        bus_a.proc_addr = 30'h5; bus_a.proc_read = 1'b0;
        tick();
        bus_a.proc_read = 1'b1;
        #1;
        check_eq("conf_hold_addr", bus_a.mem_addr, 28'h8);
        check_eq("conf_alloc_stall", bus_a.proc_stall, 1);
        bus_a.mem_ready = 1'b1; bus_a.mem_rdata = LINEB;
        tick();
        bus_a.mem_ready = 1'b0; bus_a.mem_rdata = JUNK;
        bus_a.proc_addr = 30'h21;
        #1;
        check_eq("conf_hit_stall", bus_a.proc_stall, 0);
        check_eq("conf_hit_rdata", bus_a.proc_rdata, 32'hB1B1B1B1);
        tick();
        bus_a.proc_addr = 30'h0;
        #1;
        check_eq("evict_stall", bus_a.proc_stall, 1);
        tick();
        check_eq("evict_miss_cnt", miss_a, 3);
        check_eq("evict_mem_addr", bus_a.mem_addr, 0);
        bus_a.mem_ready = 1'b1; bus_a.mem_rdata = LINE0;
        tick();
        bus_a.mem_ready = 1'b0; bus_a.proc_read = 1'b0;
        #1;
        check_eq("refill_rdata", bus_a.proc_rdata, 32'h11111111);
        check_eq("refill_hit_cnt", hit_a, 4);

        // Reset in the middle of a fill
        bus_a.proc_read = 1'b1; bus_a.proc_addr = 30'h40;
        tick();
        check_eq("rstm_mem_read_pre", bus_a.mem_read, 1);
        check_eq("rstm_mem_addr_pre", bus_a.mem_addr, 28'h10);
        rst_n = 1'b0;
        #1;
        check_eq("rstm_mem_read", bus_a.mem_read, 0);
        check_eq("rstm_mem_addr", bus_a.mem_addr, 0);
        check_eq("rstm_miss_cnt", miss_a, 0);
        check_eq("rstm_hit_cnt", hit_a, 0);
        tick();
        rst_n = 1'b1;
        bus_a.proc_read = 1'b0;
        tick();
        bus_a.mem_ready = 1'b1; bus_a.mem_rdata = LINEB;
        tick();
        bus_a.mem_ready = 1'b0;
        #1;
        check_eq("late_mem_read", bus_a.mem_read, 0);
        bus_a.proc_read = 1'b1; bus_a.proc_addr = 30'h0;
        #1;
        check_eq("late_stall", bus_a.proc_stall, 1);
        tick();
        check_eq("late_miss_cnt", miss_a, 1);
        check_eq("late_mem_read_req", bus_a.mem_read, 1);
        bus_a.mem_ready = 1'b1; bus_a.mem_rdata = LINE0;
        tick();
        bus_a.mem_ready = 1'b0; bus_a.proc_read = 1'b0;

        // Saturation on the 4-bit-counter instance
        bus_b.proc_read = 1'b1; bus_b.proc_addr = 30'h0;
        tick();
        bus_b.mem_ready = 1'b1; bus_b.mem_rdata = LINE0;
        tick();
        bus_b.mem_ready = 1'b0;
        repeat (14) tick();
        check_eq("sat_hit_cnt_14", hit_b, 4'd14);
        repeat (6) tick();
        check_eq("sat_hit_cnt_max", hit_b, 4'd15);
        check_eq("sat_miss_cnt", miss_b, 4'd1);
        check_eq("sat_rdata", bus_b.proc_rdata, 32'h11111111);
        bus_b.proc_read = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
